// File: rtl/mxreg_write_arbiter.sv
// mxreg_write_arbiter
// Shares the single register-bank write port between NREQ requesters.
// Round-robin arbitration with a per-requester valid/ready handshake, an
// optional lock that keeps the port for back-to-back writes (released by the
// owner or by an idle timeout), and registered outputs that drive the
// register-file load decoder directly.
//
// Configuration macro: MXREG_ARB_FIXED_PRI_EN
//   defined   -> fixed priority, lowest requester index wins (no rr pointer)
//   undefined -> round robin starting after the last granted index (default)
//
// Handshake: a transfer from requester i happens in a cycle where
// i_req_valid[i] & o_req_ready[i]. o_req_ready is combinational from the FSM
// state, i_req_valid and i_hold, has at most one bit set, and is never
// raised while i_hold=1. The accepted write appears on the load outputs in
// the following cycle.
module mxreg_write_arbiter #(
  parameter int WORD_LENGTH = 8,
  parameter int NREQ        = 3,
  parameter int LOCK_TMO    = 15,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NREQ-1:0]             i_req_valid,
  output logic [NREQ-1:0]             o_req_ready,
  input  logic [NREQ*8-1:0]           i_req_addr,
  input  logic [NREQ*WORD_LENGTH-1:0] i_req_data,
  input  logic [NREQ-1:0]             i_req_lock,
  input  logic                        i_hold,
  output logic                        o_load_en,
  output logic [7:0]                  o_load_addr,
  output logic [WORD_LENGTH-1:0]      o_wr_data,
  output logic [IDW-1:0]              o_grant_id,
  output logic                        o_locked,
  output logic                        o_addr_err,
  output logic                        o_dbg_state
);

  localparam int TW = $clog2(LOCK_TMO + 1);
  localparam logic [7:0] MAX_ADDR = 8'h11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_owner;
  logic [TW-1:0]    r_tmo;
`ifndef MXREG_ARB_FIXED_PRI_EN
  logic [IDW-1:0]   r_rr_ptr;
`endif

  logic                   w_win_found;
  logic [IDW-1:0]         w_win_id;
  logic [IDW-1:0]         w_idx;
  logic                   w_xfer;
  logic [IDW-1:0]         w_gid;
  logic [7:0]             w_sel_addr;
  logic [WORD_LENGTH-1:0] w_sel_data;
  logic                   w_sel_lock;

  // Arbitration winner among valid requesters (search order depends on build)
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef MXREG_ARB_FIXED_PRI_EN
      w_idx = IDW'(k);
`else
      w_idx = IDW'((int'(r_rr_ptr) + 1 + k) % NREQ);
`endif
      if (!w_win_found && i_req_valid[w_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_idx;
      end
    end
  end

  // Decide whether a transfer happens this cycle and from whom
  always_comb begin
    w_xfer = 1'b0;
    w_gid  = '0;
    if (!i_hold) begin
      if (r_state == ST_LOCKED) begin
        if (i_req_valid[r_owner]) begin
          w_xfer = 1'b1;
          w_gid  = r_owner;
        end
      end else if (w_win_found) begin
        w_xfer = 1'b1;
        w_gid  = w_win_id;
      end
    end
  end

  // Select the granted requester's address, data and lock request
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_lock = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == w_gid) begin
        w_sel_addr = i_req_addr[k*8 +: 8];
        w_sel_data = i_req_data[k*WORD_LENGTH +: WORD_LENGTH];
        w_sel_lock = i_req_lock[k];
      end
    end
  end

  assign o_req_ready = w_xfer ? (NREQ'(1) << w_gid) : '0;
  assign o_locked    = (r_state == ST_LOCKED);
  assign o_dbg_state = r_state;

  // FSM, round-robin pointer, lock timeout and registered load outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_tmo       <= '0;
`ifndef MXREG_ARB_FIXED_PRI_EN
      r_rr_ptr    <= IDW'(NREQ - 1);
`endif
      o_load_en   <= 1'b0;
      o_load_addr <= '0;
      o_wr_data   <= '0;
      o_grant_id  <= '0;
      o_addr_err  <= 1'b0;
    end else begin
      o_load_en  <= 1'b0;
      o_addr_err <= 1'b0;
      if (w_xfer) begin
        o_grant_id <= w_gid;
`ifndef MXREG_ARB_FIXED_PRI_EN
        r_rr_ptr   <= w_gid;
`endif
        // Out-of-range codes are consumed but never reach the load decoder
        if (w_sel_addr > MAX_ADDR) begin
          o_addr_err <= 1'b1;
        end else begin
          o_load_en   <= 1'b1;
          o_load_addr <= w_sel_addr;
          o_wr_data   <= w_sel_data;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_xfer && w_sel_lock) begin
            r_state <= ST_LOCKED;
            r_owner <= w_gid;
            r_tmo   <= '0;
          end
        end
        ST_LOCKED: begin
          // hold freezes the lock and its idle counter
          if (!i_hold) begin
            if (w_xfer) begin
              if (!w_sel_lock) r_state <= ST_IDLE;
              r_tmo <= '0;
            end else if (r_tmo == TW'(LOCK_TMO - 1)) begin
              r_state <= ST_IDLE;
              r_tmo   <= '0;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mxreg_write_arbiter.sv
// tb_mxreg_write_arbiter
// Directed scenarios with literal expectations, then randomized traffic.
// A behavioural model (last-granted index, lock owner, idle count) predicts
// the ready vector and the registered load outputs every cycle.
module tb_mxreg_write_arbiter;

  localparam int W        = 8;
  localparam int NREQ     = 3;
  localparam int LOCK_TMO = 15;
  localparam int IDW      = $clog2(NREQ);
  localparam int EW       = 1 + 1 + IDW + 8 + W + 1;

  typedef struct packed {
    logic           le;
    logic           ae;
    logic [IDW-1:0] gid;
    logic [7:0]     addr;
    logic [W-1:0]   data;
    logic           lk;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*8-1:0]   req_addr;
  logic [NREQ*W-1:0]   req_data;
  logic [NREQ-1:0]     req_lock;
  logic                hold;
  logic                load_en;
  logic [7:0]          load_addr;
  logic [W-1:0]        wr_data;
  logic [IDW-1:0]      grant_id;
  logic                locked;
  logic                addr_err;
  logic                dbg_state;

  mxreg_write_arbiter #(
    .WORD_LENGTH(W), .NREQ(NREQ), .LOCK_TMO(LOCK_TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_data(req_data), .i_req_lock(req_lock),
    .i_hold(hold), .o_load_en(load_en), .o_load_addr(load_addr),
    .o_wr_data(wr_data), .o_grant_id(grant_id), .o_locked(locked),
    .o_addr_err(addr_err), .o_dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] a,
                         input logic [W-1:0] d, input logic lk);
    req_valid[i]       = v;
    req_addr[i*8 +: 8] = a;
    req_data[i*W +: W] = d;
    req_lock[i]        = lk;
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  bit   m_ok = 1'b0;
  bit   m_locked;
  int   m_owner, m_last, m_idle;
  exp_t m_out;
  logic [EW-1:0] exp_q[$];

  // Index of the requester that should be accepted now, -1 if none
  function automatic int model_gnt();
    int c;
    if (hold) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 1; k <= NREQ; k++) begin
`ifdef MXREG_ARB_FIXED_PRI_EN
      c = k - 1;
`else
      c = (m_last + k) % NREQ;
`endif
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : cmp_blk
    exp_t e;
    int g;
    logic [NREQ-1:0] er;
    logic [7:0] a;
    if (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      chk("m_load_en", load_en, e.le);
      chk("m_addr_err", addr_err, e.ae);
      chk("m_grant_id", grant_id, e.gid);
      chk("m_load_addr", load_addr, e.addr);
      chk("m_wr_data", wr_data, e.data);
      chk("m_locked", locked, e.lk);
      chk("m_dbg_state", dbg_state, e.lk);
    end
    g = -1;
    if (m_ok && !rst) begin
      g  = model_gnt();
      er = (g >= 0) ? (NREQ'(1) << g) : '0;
      chk("m_ready", req_ready, er);
    end
    if (rst) begin
      m_ok     = 1'b1;
      m_locked = 1'b0;
      m_owner  = 0;
      m_idle   = 0;
      m_last   = NREQ - 1;
      m_out    = '0;
      exp_q.push_back(m_out);
    end else if (m_ok) begin
      m_out.le = 1'b0;
      m_out.ae = 1'b0;
      if (g >= 0) begin
        a = req_addr[g*8 +: 8];
        m_out.gid = IDW'(g);
        if (a > 8'h11) m_out.ae = 1'b1;
        else begin
          m_out.le   = 1'b1;
          m_out.addr = a;
          m_out.data = req_data[g*W +: W];
        end
        m_last = g;
      end
      if (!hold) begin
        if (!m_locked) begin
          if (g >= 0 && req_lock[g]) begin
            m_locked = 1'b1;
            m_owner  = g;
            m_idle   = 0;
          end
        end else if (g >= 0) begin
          if (!req_lock[g]) m_locked = 1'b0;
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == LOCK_TMO) begin
            m_locked = 1'b0;
            m_idle   = 0;
          end
        end
      end
      m_out.lk = m_locked;
      exp_q.push_back(m_out);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int vprob;
    rst = 1'b1; hold = 1'b0;
    req_valid = '0; req_lock = '0; req_addr = '0; req_data = '0;
    cycle(); cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_load_en", load_en, 1'b0);
    chk("rst_load_addr", load_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_addr_err", addr_err, 1'b0);

    // All three valid: round-robin order 0,1,2
    cycle();
    set_req(0, 1, 8'h00, 8'hA0, 0); set_req(1, 1, 8'h01, 8'hA1, 0); set_req(2, 1, 8'h02, 8'hA2, 0);
    @(negedge clk); chk("rr_ready0", req_ready, 3'b001);
    cycle(); @(negedge clk);
    chk("rr_ready1", req_ready, 3'b010); chk("rr_le0", load_en, 1'b1);
    chk("rr_addr0", load_addr, 8'h00); chk("rr_data0", wr_data, 8'hA0);
    cycle(); @(negedge clk);
    chk("rr_ready2", req_ready, 3'b100); chk("rr_addr1", load_addr, 8'h01); chk("rr_gid1", grant_id, 1);
    cycle(); req_valid = '0; @(negedge clk);
    chk("rr_addr2", load_addr, 8'h02); chk("rr_le2", load_en, 1'b1); chk("rr_gid2", grant_id, 2);
    cycle(); @(negedge clk);
    chk("rr_le_off", load_en, 1'b0); chk("rr_addr_hold", load_addr, 8'h02);

    // Lock by requester 1 for three transfers while others wait
    cycle(); set_req(1, 1, 8'h05, 8'hB1, 1);
    @(negedge clk); chk("lk_ready0", req_ready, 3'b010);
    cycle(); set_req(0, 1, 8'h03, 8'hB0, 0); set_req(2, 1, 8'h04, 8'hB2, 0);
    @(negedge clk); chk("lk_ready1", req_ready, 3'b010); chk("lk_locked1", locked, 1'b1);
    chk("lk_addr", load_addr, 8'h05);
    cycle(); req_lock[1] = 1'b0;
    @(negedge clk); chk("lk_ready2", req_ready, 3'b010); chk("lk_locked2", locked, 1'b1);
    cycle(); @(negedge clk);
    chk("lk_released", locked, 1'b0); chk("lk_next_req2", req_ready, 3'b100);
    cycle(); req_valid = '0; @(negedge clk);
    chk("lk_gid2", grant_id, 2); chk("lk_addr2", load_addr, 8'h04);

    // Lock timeout: owner 1 goes idle while requester 0 waits
    cycle(); set_req(1, 1, 8'h06, 8'hC1, 1);
    @(negedge clk); chk("tmo_ready_own", req_ready, 3'b010);
    cycle(); set_req(1, 0, 8'h06, 8'hC1, 0); set_req(0, 1, 8'h10, 8'hC0, 0);
    @(negedge clk);
    chk("tmo_locked_1", locked, 1'b1); chk("tmo_ready_1", req_ready, 3'b000);
    for (int k = 2; k <= LOCK_TMO; k++) begin
      cycle(); @(negedge clk);
      chk("tmo_locked", locked, 1'b1); chk("tmo_ready", req_ready, 3'b000);
    end
    cycle(); @(negedge clk);
    chk("tmo_released", locked, 1'b0); chk("tmo_ready_req0", req_ready, 3'b001);

    // Invalid address from requester 2 after a valid dual-register code
    cycle(); req_valid[0] = 1'b0; set_req(2, 1, 8'h12, 8'hD2, 0);
    @(negedge clk);
    chk("dual_le", load_en, 1'b1); chk("dual_addr", load_addr, 8'h10);
    chk("dual_data", wr_data, 8'hC0); chk("bad_ready", req_ready, 3'b100);
    cycle(); req_valid = '0; @(negedge clk);
    chk("bad_err", addr_err, 1'b1); chk("bad_le", load_en, 1'b0);
    chk("bad_addr_kept", load_addr, 8'h10); chk("bad_data_kept", wr_data, 8'hC0);
    chk("bad_gid", grant_id, 2);
    cycle(); @(negedge clk); chk("bad_err_pulse", addr_err, 1'b0);

    // hold for 4 cycles with everyone valid, then resume round robin
    cycle(); hold = 1'b1;
    set_req(0, 1, 8'h07, 8'hE0, 0); set_req(1, 1, 8'h08, 8'hE1, 0); set_req(2, 1, 8'h09, 8'hE2, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_ready", req_ready, 3'b000); chk("hold_le", load_en, 1'b0);
      if (k < 3) cycle();
    end
    cycle(); hold = 1'b0;
    @(negedge clk); chk("resume_ready0", req_ready, 3'b001); chk("resume_le", load_en, 1'b0);
    cycle(); @(negedge clk);
    chk("resume_ready1", req_ready, 3'b010); chk("resume_addr", load_addr, 8'h07);
    cycle(); req_valid = '0; @(negedge clk);
    chk("resume_gid", grant_id, 1); chk("resume_addr1", load_addr, 8'h08);

    // Reset while locked, with a transfer in the same cycle
    cycle(); set_req(1, 1, 8'h0A, 8'hF1, 1);
    @(negedge clk); chk("rl_ready", req_ready, 3'b010);
    cycle(); rst = 1'b1;
    @(negedge clk); chk("rl_locked", locked, 1'b1); chk("rl_addr", load_addr, 8'h0A);
    cycle(); rst = 1'b0;
    set_req(0, 1, 8'h0B, 8'hF0, 0); set_req(1, 1, 8'h0C, 8'hF1, 0); set_req(2, 1, 8'h0D, 8'hF2, 0);
    @(negedge clk);
    chk("rl_le", load_en, 1'b0); chk("rl_unlocked", locked, 1'b0);
    chk("rl_addr_rst", load_addr, 8'h00); chk("rl_ready0", req_ready, 3'b001);
    cycle(); req_valid = '0; @(negedge clk);
    chk("rl_gid0", grant_id, 0); chk("rl_le_on", load_en, 1'b1);

    // Randomized traffic, checked by the model
    for (int seg = 0; seg < 24; seg++) begin
      case (seg % 3)
        0: vprob = 5;
        1: vprob = 40;
        default: vprob = 90;
      endcase
      for (int c = 0; c < 100; c++) begin
        cycle();
        for (int i = 0; i < NREQ; i++) begin
          req_valid[i]       = ($urandom_range(0, 99) < vprob);
          req_addr[i*8 +: 8] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                           : 8'($urandom_range(0, 17));
          req_data[i*W +: W] = W'($urandom);
          req_lock[i]        = ($urandom_range(0, 2) == 0);
        end
        hold = ($urandom_range(0, 7) == 0);
        rst  = ($urandom_range(0, 199) == 0);
      end
    end
    cycle(); rst = 1'b0; hold = 1'b0; req_valid = '0;
    cycle(); cycle();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
